// File: rtl/frame_align_pkg.sv
// Shared types for the frame pair aligner: alignment state and beat bundle layout.
// A beat bundle is {tdata, tlast, tuser} with tuser in bit 0.
package frame_align_pkg;

  typedef enum logic [0:0] {
    ST_SEEK    = 1'b0,
    ST_ALIGNED = 1'b1
  } align_state_e;

  localparam int BEAT_SIDEBAND_W = 2;
  localparam int BEAT_USER_BIT   = 0;
  localparam int BEAT_LAST_BIT   = 1;

  function automatic int beat_width(input int data_width);
    return data_width + BEAT_SIDEBAND_W;
  endfunction

endpackage

// File: rtl/axis_pair_reg.sv
// One-entry joined output register: both output beats share a single valid and
// leave together only when both downstream sinks are ready.
module axis_pair_reg
  import frame_align_pkg::*;
#(
  parameter int BEAT_W = 34
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              load,
  input  logic [BEAT_W-1:0] prev_beat,
  input  logic [BEAT_W-1:0] curr_beat,
  input  logic              prev_ready,
  input  logic              curr_ready,
  output logic [BEAT_W-1:0] prev_out,
  output logic [BEAT_W-1:0] curr_out,
  output logic              pair_valid,
  output logic              consumed,
  output logic              load_en
);

  logic [BEAT_W-1:0] prev_out_r;
  logic [BEAT_W-1:0] curr_out_r;
  logic              pair_valid_r;
  logic              consumed_s;

  assign consumed_s = pair_valid_r && prev_ready && curr_ready;

  // Pair storage: a load wins over a drain so back-to-back pairs flow at full rate.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      prev_out_r   <= '0;
      curr_out_r   <= '0;
      pair_valid_r <= 1'b0;
    end else if (load) begin
      prev_out_r   <= prev_beat;
      curr_out_r   <= curr_beat;
      pair_valid_r <= 1'b1;
    end else if (consumed_s) begin
      pair_valid_r <= 1'b0;
    end else begin
      pair_valid_r <= pair_valid_r;
    end
  end

  assign prev_out   = prev_out_r;
  assign curr_out   = curr_out_r;
  assign pair_valid = pair_valid_r;
  assign consumed   = consumed_s;
  assign load_en    = !pair_valid_r || consumed_s;

endmodule

// File: rtl/frame_pair_aligner.sv
// Aligns previous-frame and current-frame pixel streams on start-of-frame and
// forwards them in lockstep. Optional mismatch counter under ALIGN_ERR_CNT_EN.
module frame_pair_aligner
  import frame_align_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  resync,
  input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
  input  logic                  s_prev_axis_tvalid,
  output logic                  s_prev_axis_tready,
  input  logic                  s_prev_axis_tlast,
  input  logic                  s_prev_axis_tuser,
  input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
  input  logic                  s_curr_axis_tvalid,
  output logic                  s_curr_axis_tready,
  input  logic                  s_curr_axis_tlast,
  input  logic                  s_curr_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_prev_axis_tdata,
  output logic                  m_prev_axis_tvalid,
  input  logic                  m_prev_axis_tready,
  output logic                  m_prev_axis_tlast,
  output logic                  m_prev_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_curr_axis_tdata,
  output logic                  m_curr_axis_tvalid,
  input  logic                  m_curr_axis_tready,
  output logic                  m_curr_axis_tlast,
  output logic                  m_curr_axis_tuser,
  output logic                  aligned
`ifdef ALIGN_ERR_CNT_EN
  , output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

  localparam int BEAT_W = beat_width(DATA_WIDTH);

  align_state_e      state_r;
  logic              aligned_r;
  logic [BEAT_W-1:0] prev_hold_r;
  logic [BEAT_W-1:0] curr_hold_r;
  logic              prev_armed_r;
  logic              curr_armed_r;

  logic [BEAT_W-1:0] prev_beat_s;
  logic [BEAT_W-1:0] curr_beat_s;
  logic [BEAT_W-1:0] load_prev_s;
  logic [BEAT_W-1:0] load_curr_s;
  logic [BEAT_W-1:0] prev_out_s;
  logic [BEAT_W-1:0] curr_out_s;
  logic              prev_ready_s;
  logic              curr_ready_s;
  logic              prev_fire_s;
  logic              curr_fire_s;
  logic              pair_fire_s;
  logic              mismatch_s;
  logic              seek_load_s;
  logic              pair_load_s;
  logic              load_en_s;
  logic              consumed_s;
  logic              pair_valid_s;

  assign prev_beat_s = {s_prev_axis_tdata, s_prev_axis_tlast, s_prev_axis_tuser};
  assign curr_beat_s = {s_curr_axis_tdata, s_curr_axis_tlast, s_curr_axis_tuser};

  // Input readiness: independent per stream while seeking, joined once aligned.
  always_comb begin
    prev_ready_s = 1'b0;
    curr_ready_s = 1'b0;
    if (areset) begin
      prev_ready_s = 1'b0;
      curr_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_SEEK: begin
          prev_ready_s = !prev_armed_r;
          curr_ready_s = !curr_armed_r;
        end
        ST_ALIGNED: begin
          prev_ready_s = s_curr_axis_tvalid && load_en_s;
          curr_ready_s = s_prev_axis_tvalid && load_en_s;
        end
        default: begin
          prev_ready_s = 1'b0;
          curr_ready_s = 1'b0;
        end
      endcase
    end
  end

  assign prev_fire_s = s_prev_axis_tvalid && prev_ready_s;
  assign curr_fire_s = s_curr_axis_tvalid && curr_ready_s;
  assign pair_fire_s = (state_r == ST_ALIGNED) && prev_fire_s && curr_fire_s;
  assign mismatch_s  = pair_fire_s &&
                       ((s_prev_axis_tuser != s_curr_axis_tuser) ||
                        (s_prev_axis_tlast != s_curr_axis_tlast));
  assign seek_load_s = (state_r == ST_SEEK) && prev_armed_r && curr_armed_r &&
                       load_en_s && !resync;
  assign pair_load_s = (pair_fire_s && !mismatch_s) || seek_load_s;

  // Output pair source: the held SOF beats when leaving SEEK, live beats otherwise.
  always_comb begin
    load_prev_s = prev_beat_s;
    load_curr_s = curr_beat_s;
    if (seek_load_s) begin
      load_prev_s = prev_hold_r;
      load_curr_s = curr_hold_r;
    end else begin
      load_prev_s = prev_beat_s;
      load_curr_s = curr_beat_s;
    end
  end

  // Alignment state machine with hold registers and armed flags.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r      <= ST_SEEK;
      aligned_r    <= 1'b0;
      prev_hold_r  <= '0;
      curr_hold_r  <= '0;
      prev_armed_r <= 1'b0;
      curr_armed_r <= 1'b0;
    end else if (resync) begin
      state_r      <= ST_SEEK;
      aligned_r    <= 1'b0;
      prev_hold_r  <= '0;
      curr_hold_r  <= '0;
      prev_armed_r <= 1'b0;
      curr_armed_r <= 1'b0;
    end else begin
      case (state_r)
        ST_SEEK: begin
          if (seek_load_s) begin
            state_r      <= ST_ALIGNED;
            aligned_r    <= 1'b1;
            prev_armed_r <= 1'b0;
            curr_armed_r <= 1'b0;
          end else begin
            if (prev_fire_s && s_prev_axis_tuser) begin
              prev_hold_r  <= prev_beat_s;
              prev_armed_r <= 1'b1;
            end
            if (curr_fire_s && s_curr_axis_tuser) begin
              curr_hold_r  <= curr_beat_s;
              curr_armed_r <= 1'b1;
            end
          end
        end
        ST_ALIGNED: begin
          // A mismatching beat that carries SOF seeds the next alignment directly.
          if (mismatch_s) begin
            state_r   <= ST_SEEK;
            aligned_r <= 1'b0;
            if (s_prev_axis_tuser) begin
              prev_hold_r  <= prev_beat_s;
              prev_armed_r <= 1'b1;
            end
            if (s_curr_axis_tuser) begin
              curr_hold_r  <= curr_beat_s;
              curr_armed_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ST_SEEK;
          aligned_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALIGN_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  // Saturating mismatch counter; still counts when resync coincides.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_cnt_r <= '0;
    end else if (mismatch_s && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_count = err_cnt_r;
`endif

  axis_pair_reg #(
    .BEAT_W (BEAT_W)
  ) u_pair_reg (
    .aclk       (aclk),
    .areset     (areset),
    .load       (pair_load_s),
    .prev_beat  (load_prev_s),
    .curr_beat  (load_curr_s),
    .prev_ready (m_prev_axis_tready),
    .curr_ready (m_curr_axis_tready),
    .prev_out   (prev_out_s),
    .curr_out   (curr_out_s),
    .pair_valid (pair_valid_s),
    .consumed   (consumed_s),
    .load_en    (load_en_s)
  );

  assign s_prev_axis_tready = prev_ready_s;
  assign s_curr_axis_tready = curr_ready_s;

  assign m_prev_axis_tdata  = prev_out_s[BEAT_W-1:BEAT_SIDEBAND_W];
  assign m_prev_axis_tlast  = prev_out_s[BEAT_LAST_BIT];
  assign m_prev_axis_tuser  = prev_out_s[BEAT_USER_BIT];
  assign m_prev_axis_tvalid = pair_valid_s;
  assign m_curr_axis_tdata  = curr_out_s[BEAT_W-1:BEAT_SIDEBAND_W];
  assign m_curr_axis_tlast  = curr_out_s[BEAT_LAST_BIT];
  assign m_curr_axis_tuser  = curr_out_s[BEAT_USER_BIT];
  assign m_curr_axis_tvalid = pair_valid_s;

  assign aligned = aligned_r;

endmodule

// File: tb/tb_frame_pair_aligner.sv
// Self-checking bench for frame_pair_aligner: scenario table, directed resync
// sequence, and randomized streams checked against a sequence-level model.
module tb_frame_pair_aligner;

  localparam int DW = 32;
  localparam int EW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic          resync;
  logic [DW-1:0] s_prev_axis_tdata,  s_curr_axis_tdata;
  logic          s_prev_axis_tvalid, s_curr_axis_tvalid;
  logic          s_prev_axis_tready, s_curr_axis_tready;
  logic          s_prev_axis_tlast,  s_curr_axis_tlast;
  logic          s_prev_axis_tuser,  s_curr_axis_tuser;
  logic [DW-1:0] m_prev_axis_tdata,  m_curr_axis_tdata;
  logic          m_prev_axis_tvalid, m_curr_axis_tvalid;
  logic          m_prev_axis_tready, m_curr_axis_tready;
  logic          m_prev_axis_tlast,  m_curr_axis_tlast;
  logic          m_prev_axis_tuser,  m_curr_axis_tuser;
  logic          aligned;
`ifdef ALIGN_ERR_CNT_EN
  logic [EW-1:0] err_count;
`endif

  frame_pair_aligner #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .aclk(aclk), .areset(areset), .resync(resync),
    .s_prev_axis_tdata(s_prev_axis_tdata), .s_prev_axis_tvalid(s_prev_axis_tvalid),
    .s_prev_axis_tready(s_prev_axis_tready), .s_prev_axis_tlast(s_prev_axis_tlast),
    .s_prev_axis_tuser(s_prev_axis_tuser),
    .s_curr_axis_tdata(s_curr_axis_tdata), .s_curr_axis_tvalid(s_curr_axis_tvalid),
    .s_curr_axis_tready(s_curr_axis_tready), .s_curr_axis_tlast(s_curr_axis_tlast),
    .s_curr_axis_tuser(s_curr_axis_tuser),
    .m_prev_axis_tdata(m_prev_axis_tdata), .m_prev_axis_tvalid(m_prev_axis_tvalid),
    .m_prev_axis_tready(m_prev_axis_tready), .m_prev_axis_tlast(m_prev_axis_tlast),
    .m_prev_axis_tuser(m_prev_axis_tuser),
    .m_curr_axis_tdata(m_curr_axis_tdata), .m_curr_axis_tvalid(m_curr_axis_tvalid),
    .m_curr_axis_tready(m_curr_axis_tready), .m_curr_axis_tlast(m_curr_axis_tlast),
    .m_curr_axis_tuser(m_curr_axis_tuser),
    .aligned(aligned)
`ifdef ALIGN_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    int pj; int cj; int w; int h; int frames; int early;
    int exp_pairs; int exp_err; bit exp_aligned;
  } scen_t;

  beat_t q_prev[$], q_curr[$], exp_prev[$], exp_curr[$], got_prev[$], got_curr[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input bit to_curr, input logic [DW-1:0] d, input bit last, input bit user);
    beat_t b;
    b.data = d; b.last = last; b.user = user;
    if (to_curr) q_curr.push_back(b);
    else q_prev.push_back(b);
  endtask

  // junk pixels, then frames of w x h; on early_frame the first row's tlast moves one pixel left
  task automatic gen(input bit to_curr, input int junk, input int w, input int h,
                     input int frames, input int early_frame, input logic [DW-1:0] base);
    for (int j = 0; j < junk; j++) push(to_curr, base + 32'h0000_0F00 + 32'(j), 1'b0, 1'b0);
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          bit lst;
          lst = (x == w - 1);
          if (f == early_frame && y == 0 && w >= 2) lst = (x == w - 2);
          push(to_curr, base + 32'(f * 4096 + y * 64 + x), lst, (x == 0 && y == 0));
        end
  endtask

  // Reference: walk both beat sequences, drop to SOF, pair in lockstep, reseek on any mismatch.
  task automatic model();
    int ip = 0, ic = 0, hp = -1, hc = -1, e = 0;
    bit seek = 1'b1, done = 1'b0;
    exp_prev.delete(); exp_curr.delete();
    while (!done) begin
      if (seek) begin
        while (hp < 0 && ip < q_prev.size()) begin if (q_prev[ip].user) hp = ip; ip++; end
        while (hc < 0 && ic < q_curr.size()) begin if (q_curr[ic].user) hc = ic; ic++; end
        if (hp < 0 || hc < 0) done = 1'b1;
        else begin
          exp_prev.push_back(q_prev[hp]); exp_curr.push_back(q_curr[hc]);
          hp = -1; hc = -1; seek = 1'b0;
        end
      end else if (ip >= q_prev.size() || ic >= q_curr.size()) begin
        done = 1'b1;
      end else begin
        if (q_prev[ip].user == q_curr[ic].user && q_prev[ip].last == q_curr[ic].last) begin
          exp_prev.push_back(q_prev[ip]); exp_curr.push_back(q_curr[ic]);
        end else begin
          e++; seek = 1'b1;
          if (q_prev[ip].user) hp = ip;
          if (q_curr[ic].user) hc = ic;
        end
        ip++; ic++;
      end
    end
    exp_err = (e > (2 ** EW) - 1) ? (2 ** EW) - 1 : e;
  endtask

  task automatic do_reset();
    areset = 1'b1; resync = 1'b0;
    s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
    s_prev_axis_tdata = '0; s_prev_axis_tlast = 1'b0; s_prev_axis_tuser = 1'b0;
    s_curr_axis_tdata = '0; s_curr_axis_tlast = 1'b0; s_curr_axis_tuser = 1'b0;
    m_prev_axis_tready = 1'b1; m_curr_axis_tready = 1'b1;
    q_prev.delete(); q_curr.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_rdy", {s_prev_axis_tready, s_curr_axis_tready}, 64'd0);
    chk("rst_m_valid", {m_prev_axis_tvalid, m_curr_axis_tvalid}, 64'd0);
    chk("rst_m_data", {m_prev_axis_tdata, m_curr_axis_tdata}, 64'd0);
    chk("rst_m_side", {m_prev_axis_tlast, m_prev_axis_tuser, m_curr_axis_tlast, m_curr_axis_tuser}, 64'd0);
    chk("rst_aligned", aligned, 64'd0);
`ifdef ALIGN_ERR_CNT_EN
    chk("rst_err", err_count, 64'd0);
`endif
    tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("seek_s_rdy", {s_prev_axis_tready, s_curr_axis_tready}, 64'd3);
  endtask

  // Drive q_prev/q_curr with gaps (pct) and output backpressure (pct), then score against the model.
  task automatic run(input int pg, input int cg, input int mpb, input int mcb);
    int ip = 0, ic = 0, idle = 0, cyc = 0;
    bit pf, cf, of, hold_v = 1'b0;
    beat_t cur_p, cur_c, snap_p, snap_c;
    model();
    got_prev.delete(); got_curr.delete();
    while (idle < 40 && cyc < 5000) begin
      @(negedge aclk);
      pf = s_prev_axis_tvalid && s_prev_axis_tready;
      cf = s_curr_axis_tvalid && s_curr_axis_tready;
      of = m_prev_axis_tvalid && m_prev_axis_tready && m_curr_axis_tready;
      cur_p = {m_prev_axis_tdata, m_prev_axis_tlast, m_prev_axis_tuser};
      cur_c = {m_curr_axis_tdata, m_curr_axis_tlast, m_curr_axis_tuser};
      chk("valid_equal", m_prev_axis_tvalid, m_curr_axis_tvalid);
      if (hold_v) begin
        chk("hold_valid", m_prev_axis_tvalid, 64'd1);
        chk("hold_data", {cur_p, cur_c}, {snap_p, snap_c});
      end
      if (of) begin got_prev.push_back(cur_p); got_curr.push_back(cur_c); end
      hold_v = m_prev_axis_tvalid && !of;
      snap_p = cur_p; snap_c = cur_c;
      idle = (pf || cf || of) ? 0 : idle + 1;
      tick();
      cyc++;
      if (pf) ip++;
      if (cf) ic++;
      if (!s_prev_axis_tvalid || pf) begin
        s_prev_axis_tvalid = (ip < q_prev.size()) && ($urandom_range(99) >= pg);
        if (ip < q_prev.size()) {s_prev_axis_tdata, s_prev_axis_tlast, s_prev_axis_tuser} = q_prev[ip];
      end
      if (!s_curr_axis_tvalid || cf) begin
        s_curr_axis_tvalid = (ic < q_curr.size()) && ($urandom_range(99) >= cg);
        if (ic < q_curr.size()) {s_curr_axis_tdata, s_curr_axis_tlast, s_curr_axis_tuser} = q_curr[ic];
      end
      m_prev_axis_tready = ($urandom_range(99) >= mpb);
      m_curr_axis_tready = ($urandom_range(99) >= mcb);
    end
    chk("run_bound", cyc < 5000, 64'd1);
    s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
    m_prev_axis_tready = 1'b1; m_curr_axis_tready = 1'b1;
    chk("pair_count", got_prev.size(), exp_prev.size());
    for (int i = 0; i < got_prev.size() && i < exp_prev.size(); i++) begin
      chk("pair_prev", got_prev[i], exp_prev[i]);
      chk("pair_curr", got_curr[i], exp_curr[i]);
    end
`ifdef ALIGN_ERR_CNT_EN
    chk("err_count", err_count, exp_err);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    scen_t tbl[6];
    tbl[0] = '{pj:5, cj:0, w:4, h:2, frames:1, early:-1, exp_pairs:8,  exp_err:0, exp_aligned:1};
    tbl[1] = '{pj:0, cj:0, w:4, h:2, frames:2, early:-1, exp_pairs:16, exp_err:0, exp_aligned:1};
    tbl[2] = '{pj:0, cj:0, w:4, h:2, frames:2, early:0,  exp_pairs:10, exp_err:1, exp_aligned:1};
    tbl[3] = '{pj:3, cj:1, w:2, h:3, frames:1, early:-1, exp_pairs:6,  exp_err:0, exp_aligned:1};
    tbl[4] = '{pj:0, cj:2, w:3, h:1, frames:3, early:0,  exp_pairs:7,  exp_err:1, exp_aligned:1};
    tbl[5] = '{pj:0, cj:0, w:4, h:1, frames:1, early:0,  exp_pairs:2,  exp_err:1, exp_aligned:0};

    for (int s = 0; s < 6; s++) begin
      do_reset();
      gen(1'b0, tbl[s].pj, tbl[s].w, tbl[s].h, tbl[s].frames, -1, 32'h1000_0000);
      gen(1'b1, tbl[s].cj, tbl[s].w, tbl[s].h, tbl[s].frames, tbl[s].early, 32'h2000_0000);
      run(0, 0, 0, 0);
      chk("tbl_pairs", got_prev.size(), tbl[s].exp_pairs);
`ifdef ALIGN_ERR_CNT_EN
      chk("tbl_err", err_count, tbl[s].exp_err);
`endif
      @(negedge aclk);
      chk("tbl_aligned", aligned, tbl[s].exp_aligned);
      if (got_prev.size() > 0)
        chk("tbl_first", {got_prev[0].data, got_prev[0].user, got_curr[0].data, got_curr[0].user},
            {32'h1000_0000, 1'b1, 32'h2000_0000, 1'b1});
    end

    // Repeated tlast mismatches drive the counter into saturation.
    do_reset();
    for (int r = 0; r < 20; r++) begin
      push(1'b0, 32'h3000_0000 + 32'(r), 1'b0, 1'b1); push(1'b0, 32'h3100_0000, 1'b1, 1'b0);
      push(1'b1, 32'h4000_0000 + 32'(r), 1'b0, 1'b1); push(1'b1, 32'h4100_0000, 1'b0, 1'b0);
    end
    run(0, 0, 0, 0);
    chk("sat_pairs", got_prev.size(), 64'd20);
`ifdef ALIGN_ERR_CNT_EN
    chk("sat_err", err_count, 64'hF);
`endif

    // SOF capture latency, then resync with an unconsumed pair pending.
    do_reset();
    m_prev_axis_tready = 1'b0; m_curr_axis_tready = 1'b0;
    {s_prev_axis_tdata, s_prev_axis_tlast, s_prev_axis_tuser, s_prev_axis_tvalid} = {32'hA0A0_0001, 3'b011};
    {s_curr_axis_tdata, s_curr_axis_tlast, s_curr_axis_tuser, s_curr_axis_tvalid} = {32'hB0B0_0001, 3'b011};
    tick();
    s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("armed_rdy", {s_prev_axis_tready, s_curr_axis_tready}, 64'd0);
    chk("lat_valid0", m_prev_axis_tvalid, 64'd0);
    tick();
    @(negedge aclk);
    chk("lat_valid1", {m_prev_axis_tvalid, m_curr_axis_tvalid, aligned}, 64'd7);
    chk("sof_pair", {m_prev_axis_tdata, m_prev_axis_tuser, m_curr_axis_tdata, m_curr_axis_tuser},
        {32'hA0A0_0001, 1'b1, 32'hB0B0_0001, 1'b1});
    {s_prev_axis_tdata, s_prev_axis_tuser, s_prev_axis_tvalid} = {32'hA0A0_0002, 2'b01};
    {s_curr_axis_tdata, s_curr_axis_tuser, s_curr_axis_tvalid} = {32'hB0B0_0002, 2'b01};
    #1;
    chk("stall_rdy", {s_prev_axis_tready, s_curr_axis_tready}, 64'd0);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk("resync_aligned", aligned, 64'd0);
      chk("resync_hold", {m_prev_axis_tvalid, m_prev_axis_tdata, m_curr_axis_tdata},
          {1'b1, 32'hA0A0_0001, 32'hB0B0_0001});
      tick();
    end
    m_prev_axis_tready = 1'b1; m_curr_axis_tready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("drop_no_valid", m_prev_axis_tvalid, 64'd0);
      chk("drop_rdy", {s_prev_axis_tready, s_curr_axis_tready}, 64'd3);
      tick();
    end
    {s_prev_axis_tdata, s_prev_axis_tuser} = {32'hC0C0_0000, 1'b1};
    {s_curr_axis_tdata, s_curr_axis_tuser} = {32'hD0D0_0000, 1'b1};
    tick();
    s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
    tick();
    @(negedge aclk);
    chk("realign_pair", {m_prev_axis_tvalid, aligned, m_prev_axis_tdata, m_curr_axis_tdata},
        {2'b11, 32'hC0C0_0000, 32'hD0D0_0000});
    tick();

    // Randomized streams: geometry faults, early tlast, input gaps, output backpressure.
    for (int r = 0; r < 8; r++) begin
      int w, h, fr, cw;
      do_reset();
      w  = $urandom_range(4, 1);
      h  = $urandom_range(3, 1);
      fr = $urandom_range(3, 1);
      cw = (r % 3 == 2) ? w + 1 : w;
      gen(1'b0, $urandom_range(4), w, h, fr, -1, $urandom);
      gen(1'b1, $urandom_range(4), cw, h, fr, (r % 2 == 1) ? 0 : -1, $urandom);
      if (r % 2 == 0) run($urandom_range(40), $urandom_range(40), 0, 50);
      else run($urandom_range(40), $urandom_range(40), 30, 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_pair_aligner.md
# frame_pair_aligner

Frame-alignment stage directly upstream of the temporal denoise core. Accepts the previous-frame stream (frame-buffer readback) and the current-frame stream (sensor/VDMA), discards pixels on each until it sees start-of-frame (tuser), then forwards both streams in pixel lockstep as one joined pair. The denoise core therefore always receives matching pixel positions. Any tuser/tlast mismatch between the two streams forces a resynchronisation.

## Interface
- DATA_WIDTH, 32, pixel word width on all four streams
- ERR_CNT_WIDTH, 16, width of the mismatch counter

- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- resync  in  1  single-cycle pulse; forces a return to SEEK
- s_prev_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  previous-frame input
- s_curr_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  current-frame input
- m_prev_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  aligned previous-frame output
- m_curr_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  aligned current-frame output
- aligned  out  1  high while in ALIGNED
- err_count  out  ERR_CNT_WIDTH  saturating mismatch count (ALIGN_ERR_CNT_EN only)

## Operation
- Two states: SEEK and ALIGNED. Each input has a one-entry hold register plus an armed flag.
- SEEK:
  - An unarmed input has tready=1. Non-tuser beats are dropped.
  - A tuser beat is captured into that input's hold register, armed is set, and that input's tready drops to 0.
  - When both inputs are armed, the held pair loads into the output pair register (if empty or draining), both armed flags clear, and the state goes to ALIGNED.
- ALIGNED, joined transfer:
  - s_prev_axis_tready = s_curr_axis_tvalid && load_en.
  - s_curr_axis_tready = s_prev_axis_tvalid && load_en.
  - load_en = output register empty, or pair consumed this cycle.
- Output pair register:
  - m_prev_axis_tvalid and m_curr_axis_tvalid are always equal.
  - The pair is consumed only when m_prev_axis_tready && m_curr_axis_tready.
  - Valid never depends on ready. Data and sideband are stable while valid && !consumed.
- Mismatch: an accepted pair whose tuser bits differ, or whose tlast bits differ, is not forwarded. The block then increments err_count and enters SEEK.
  - Any beat of that pair carrying tuser=1 is captured straight into its hold register, with armed set, so that SOF is not lost.
- resync:
  - Enters SEEK next cycle and clears both armed flags and hold registers.
  - A pending output pair is kept until consumed, so the AXI valid is never withdrawn.
  - resync coinciding with a mismatch gives SEEK with no SOF capture. The counter still increments.
- err_count saturates at all-ones and does not wrap.

## Timing
- Reset values:
  - All m_* tdata/tvalid/tlast/tuser = 0.
  - aligned = 0, err_count = 0, state = SEEK, armed flags = 0.
  - All s_* tready = 0 while areset is high. After reset deasserts, tready is driven by state logic.
- Latency:
  - Input pair acceptance to output valid: 1 cycle.
  - Steady-state throughput: 1 pair/cycle when both outputs are ready.
- SEEK to ALIGNED: first output valid 1 cycle after the later of the two tuser captures.
- aligned is registered: asserts the same cycle the SOF pair appears at the output, and deasserts the cycle after the mismatch or resync is detected.

## Configuration
- ALIGN_ERR_CNT_EN:
  - Defined: err_count port and the saturating counter are present.
  - Undefined: the port and counter are removed. Mismatch still forces SEEK. All other behaviour is identical.

## Structure
- Package frame_align_pkg holds:
  - the state typedef (ST_SEEK, ST_ALIGNED)
  - the width of the stream beat bundle: DATA_WIDTH+2 covering tdata, tlast and tuser
- One sub-module: axis_pair_reg, the one-entry joined output register. It takes a load strobe and both beats, and produces paired valid plus the consumed signal.

## Test plan
- Prev stream starts 5 pixels before SOF, curr starts at SOF → 5 prev beats dropped; first output pair is prev tuser beat + curr tuser beat; aligned=1.
- 4x2 frames on both streams, outputs always ready → 8 pairs at 1/cycle; tlast on pairs 4 and 8; tdata pass unchanged.
- Random backpressure on m_curr only → no pair advances while m_curr_axis_tready=0; output data stays stable; no beat is lost or duplicated.
- Curr tlast one pixel early → pair not forwarded; err_count 0→1; SEEK; realigns on the next tuser of both streams.
- resync pulse while an output pair is pending and unconsumed → pair held until consumed; then inputs drop beats until the next SOF.
- Force 2^16 mismatches with ERR_CNT_WIDTH=16 → err_count stays 0xFFFF.
